signal_router: RTL and testbench

- Parametrised N-channel sample router, successor to the two-channel A/B switch.
- Any output channel can take any input channel, under a per-output select map.
- Map changes are double-buffered. They apply only on a sample boundary, followed by a programmable output blanking window, so no torn or mixed samples reach downstream filters.
- Sits between the ADC/DSP sample stream and the FIFO/DMA stage; runs on the system clock.

---
 rtl/signal_router.sv | 154 +++++++++++++++
 tb/tb_signal_router.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/signal_router.sv
// N-channel sample router with a double-buffered select map that switches on a sample boundary
// and then blanks the output. Optional build macro: SIGNAL_ROUTER_INVERT_EN (per-output saturated negation).
module signal_router #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 4,
  parameter int SEL_WIDTH    = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         SYS_aclk,
  input  logic                         SYS_aresetn,
  input  logic                         in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH*SEL_WIDTH-1:0]  sel_map,
  input  logic                         sel_update,
`ifdef SIGNAL_ROUTER_INVERT_EN
  input  logic [NUM_CH-1:0]            invert,
`endif
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic [NUM_CH*SEL_WIDTH-1:0]  active_map
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PENDING,
    ST_BLANK
  } state_t;

  function automatic logic [NUM_CH*SEL_WIDTH-1:0] identity_map();
    logic [NUM_CH*SEL_WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_CH; j++) m[j*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(j);
    return m;
  endfunction

  localparam logic [NUM_CH*SEL_WIDTH-1:0] IDENTITY = identity_map();
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t                        r_state;
  logic [7:0]                    r_blank_cnt;
  logic                          r_busy;
  logic                          r_out_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]  r_out_data;
  logic [NUM_CH*SEL_WIDTH-1:0]   r_shadow_map;
  logic [NUM_CH*SEL_WIDTH-1:0]   r_active_map;
`ifdef SIGNAL_ROUTER_INVERT_EN
  logic [NUM_CH-1:0]             r_shadow_inv;
  logic [NUM_CH-1:0]             r_active_inv;
  logic [NUM_CH-1:0]             w_inv;
`endif

  logic                          w_use_shadow;
  logic                          w_zero;
  logic [NUM_CH*SEL_WIDTH-1:0]   w_map;
  logic [SEL_WIDTH-1:0]          w_sel;
  logic [DATA_WIDTH-1:0]         w_sample [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0]  w_next_data;

  // The switching sample is routed with the shadow map, so the new map takes effect on that very sample.
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path can infer a latch.
    w_use_shadow = (r_state == ST_PENDING) && in_valid && !sel_update;
    w_map        = w_use_shadow ? r_shadow_map : r_active_map;
    w_zero       = (r_state == ST_BLANK) || (w_use_shadow && (BLANK_CYCLES != 0));
    w_sel        = '0;
    w_next_data  = '0;
`ifdef SIGNAL_ROUTER_INVERT_EN
    w_inv        = w_use_shadow ? r_shadow_inv : r_active_inv;
`endif
    for (int j = 0; j < NUM_CH; j++) begin
      w_sample[j] = '0;
      w_sel       = w_map[j*SEL_WIDTH +: SEL_WIDTH];
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_sel == SEL_WIDTH'(i)) w_sample[j] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef SIGNAL_ROUTER_INVERT_EN
      if (w_inv[j]) w_sample[j] = (w_sample[j] == S_MIN) ? S_MAX : -w_sample[j];
`endif
      if (!w_zero) w_next_data[j*DATA_WIDTH +: DATA_WIDTH] = w_sample[j];
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      r_state      <= ST_RUN;
      r_blank_cnt  <= '0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_shadow_map <= IDENTITY;
      r_active_map <= IDENTITY;
`ifdef SIGNAL_ROUTER_INVERT_EN
      r_shadow_inv <= '0;
      r_active_inv <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= in_valid;
      if (in_valid) r_out_data <= w_next_data;

      if (sel_update) begin
        // A new request always wins: it restarts the change and abandons any blanking in progress.
        r_shadow_map <= sel_map;
`ifdef SIGNAL_ROUTER_INVERT_EN
        r_shadow_inv <= invert;
`endif
        r_state      <= ST_PENDING;
        r_busy       <= 1'b1;
        r_blank_cnt  <= '0;
      end else begin
        case (r_state)
          ST_RUN: ;
          ST_PENDING: begin
            if (in_valid) begin
              r_active_map <= r_shadow_map;
`ifdef SIGNAL_ROUTER_INVERT_EN
              r_active_inv <= r_shadow_inv;
`endif
              // The switching sample is itself the first blanked one, hence BLANK_CYCLES-1 remain.
              if (BLANK_CYCLES <= 1) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
              end else begin
                r_state     <= ST_BLANK;
                r_blank_cnt <= 8'(BLANK_CYCLES - 1);
              end
            end
          end
          ST_BLANK: begin
            if (in_valid) begin
              r_blank_cnt <= r_blank_cnt - 8'd1;
              if (r_blank_cnt == 8'd1) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign active_map = r_active_map;

endmodule

// File: tb/tb_signal_router.sv
// Directed bench for signal_router (NUM_CH=4, DATA_WIDTH=16, BLANK_CYCLES=4); exercises the
// invert option as well when SIGNAL_ROUTER_INVERT_EN is defined.
module tb_signal_router;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int SW = 4;
  localparam int BC = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC*SW-1:0] sel_map;
  logic           sel_update;
  logic           out_valid;
  logic [NC*DW-1:0] out_data;
  logic           busy;
  logic [NC*SW-1:0] active_map;
`ifdef SIGNAL_ROUTER_INVERT_EN
  logic [NC-1:0]  invert;
`endif

  int n_vec = 0;
  int n_err = 0;

  signal_router #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NC),
    .SEL_WIDTH   (SW),
    .BLANK_CYCLES(BC)
  ) dut (
    .SYS_aclk   (clk),
    .SYS_aresetn(rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .sel_map    (sel_map),
    .sel_update (sel_update),
`ifdef SIGNAL_ROUTER_INVERT_EN
    .invert     (invert),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .active_map (active_map)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NC*DW-1:0] pk(input logic [DW-1:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
  task automatic cycle(input logic v, input logic [NC*DW-1:0] d, input logic u, input logic [NC*SW-1:0] m);
    in_valid   = v;
    in_data    = d;
    sel_update = u;
    sel_map    = m;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    sel_update = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if ({out_valid, busy, out_data, active_map} !== {1'b0, 1'b0, 64'h0, 16'h3210}) begin
      n_err++;
      $display("FAIL reset: valid=%b busy=%b data=%h map=%h, want 0 0 0 3210", out_valid, busy, out_data, active_map);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [NC*DW-1:0] d;
    d = pk(16'h0004, 16'h0003, 16'h0002, 16'h0001);
    cycle(1'b1, d, 1'b0, 16'h3210);
    n_vec++;
    if ({out_valid, busy, out_data} !== {1'b1, 1'b0, d}) begin
      n_err++;
      $display("FAIL passthrough: valid=%b busy=%b data=%h, want 1 0 %h", out_valid, busy, out_data, d);
    end
    cycle(1'b0, 64'hdead_beef_dead_beef, 1'b0, 16'h3210);
    n_vec++;
    if ({out_valid, out_data} !== {1'b0, d}) begin
      n_err++;
      $display("FAIL hold: valid=%b data=%h, want 0 %h", out_valid, out_data, d);
    end
  endtask

  task automatic test_map_change();
    logic [NC*DW-1:0] d, exp;
    d = pk(16'h00a4, 16'h00a3, 16'h00a2, 16'h00a1);
    // Update and sample in the same RUN cycle: the sample still uses the identity map.
    cycle(1'b1, d, 1'b1, 16'h0123);
    n_vec++;
    if ({out_data, busy, active_map} !== {d, 1'b1, 16'h3210}) begin
      n_err++;
      $display("FAIL same_cycle_update: data=%h busy=%b map=%h, want %h 1 3210", out_data, busy, active_map, d);
    end
    for (int k = 1; k <= 6; k++) begin
      d   = pk(16'h0400 + 16'(k), 16'h0300 + 16'(k), 16'h0200 + 16'(k), 16'h0100 + 16'(k));
      exp = (k <= BC) ? '0 : pk(16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k), 16'h0400 + 16'(k));
      cycle(1'b1, d, 1'b0, 16'h0123);
      n_vec++;
      if ({out_valid, out_data, busy, active_map} !== {1'b1, exp, (k < BC), 16'h0123}) begin
        n_err++;
        $display("FAIL reverse_strobe%0d: valid=%b data=%h busy=%b map=%h, want 1 %h %b 0123",
                 k, out_valid, out_data, busy, active_map, exp, (k < BC));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [NC*DW-1:0] d;
    d = pk(16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    cycle(1'b0, d, 1'b1, 16'h3710);
    for (int k = 1; k <= BC; k++) cycle(1'b1, d, 1'b0, 16'h3710);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL oor_busy: busy=%b, want 0", busy);
    end
    cycle(1'b1, d, 1'b0, 16'h3710);
    n_vec++;
    if (out_data !== pk(16'h1234, 16'h0000, 16'h9abc, 16'hdef0)) begin
      n_err++;
      $display("FAIL out_of_range: data=%h, want 1234_0000_9abc_def0", out_data);
    end
  endtask

  task automatic test_update_during_blank();
    logic [NC*DW-1:0] d, exp;
    d = pk(16'h0d00, 16'h0c00, 16'h0b00, 16'h0a00);
    cycle(1'b0, d, 1'b1, 16'h0123);
    cycle(1'b1, d, 1'b0, 16'h0123);
    cycle(1'b1, d, 1'b0, 16'h0123);
    cycle(1'b0, d, 1'b1, 16'h1032);
    cycle(1'b0, d, 1'b0, 16'h1032);
    n_vec++;
    if ({busy, active_map} !== {1'b1, 16'h0123}) begin
      n_err++;
      $display("FAIL reupdate_pending: busy=%b map=%h, want 1 0123", busy, active_map);
    end
    for (int k = 1; k <= BC + 1; k++) begin
      exp = (k <= BC) ? '0 : pk(16'h0b00, 16'h0a00, 16'h0d00, 16'h0c00);
      cycle(1'b1, d, 1'b0, 16'h1032);
      n_vec++;
      if ({out_data, busy, active_map} !== {exp, (k < BC), 16'h1032}) begin
        n_err++;
        $display("FAIL reblank_strobe%0d: data=%h busy=%b map=%h, want %h %b 1032",
                 k, out_data, busy, active_map, exp, (k < BC));
      end
    end
  endtask

  task automatic test_reset_mid_blank();
    logic [NC*DW-1:0] d;
    d = pk(16'h0044, 16'h0033, 16'h0022, 16'h0011);
    cycle(1'b0, d, 1'b1, 16'h0123);
    cycle(1'b1, d, 1'b0, 16'h0123);
    cycle(1'b1, d, 1'b0, 16'h0123);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, busy, out_data, active_map} !== {1'b0, 1'b0, 64'h0, 16'h3210}) begin
      n_err++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h map=%h, want 0 0 0 3210", out_valid, busy, out_data, active_map);
    end
    #2 rst_n = 1'b1;
    cycle(1'b1, d, 1'b0, 16'h0123);
    n_vec++;
    if ({out_data, busy} !== {d, 1'b0}) begin
      n_err++;
      $display("FAIL after_reset: data=%h busy=%b, want %h 0", out_data, busy, d);
    end
  endtask

`ifdef SIGNAL_ROUTER_INVERT_EN
  task automatic test_invert();
    logic [NC*DW-1:0] d;
    invert = 4'b0001;
    cycle(1'b0, '0, 1'b1, 16'h3210);
    invert = 4'b0000;
    for (int k = 1; k <= BC; k++) cycle(1'b1, '0, 1'b0, 16'h3210);
    d = pk(16'h0004, 16'h0003, 16'h0002, 16'h8000);
    cycle(1'b1, d, 1'b0, 16'h3210);
    n_vec++;
    if (out_data !== pk(16'h0004, 16'h0003, 16'h0002, 16'h7fff)) begin
      n_err++;
      $display("FAIL invert_sat: data=%h, want 0004_0003_0002_7fff", out_data);
    end
    d = pk(16'h0004, 16'h0003, 16'h0002, 16'h0005);
    cycle(1'b1, d, 1'b0, 16'h3210);
    n_vec++;
    if (out_data !== pk(16'h0004, 16'h0003, 16'h0002, 16'hfffb)) begin
      n_err++;
      $display("FAIL invert_neg: data=%h, want 0004_0003_0002_fffb", out_data);
    end
  endtask
`endif

  initial begin
    in_valid   = 1'b0;
    in_data    = '0;
    sel_map    = 16'h3210;
    sel_update = 1'b0;
`ifdef SIGNAL_ROUTER_INVERT_EN
    invert     = '0;
`endif
    test_reset();
    test_passthrough();
    test_map_change();
    test_out_of_range();
    test_update_during_blank();
    test_reset_mid_blank();
`ifdef SIGNAL_ROUTER_INVERT_EN
    test_invert();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
